// File: rtl/if_fetch.sv
// Instruction fetch unit: assembles a 32-bit little-endian word from four
// consecutive byte reads, with branch flush, misalignment detection and global stall.
module if_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] pc,
  input  logic        ce,
  input  logic        br,
  input  logic        mem_busy,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a,
  output logic        mem_req,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        misalign,
  output logic        stall_req
);

  typedef enum logic [2:0] {IDLE, B0, B1, B2, B3, B4} state_t;

  state_t      state_reg, state_next;
  logic [31:0] fpc_reg, fpc_next;
  logic [31:0] mem_a_reg, mem_a_next;
  logic        mem_req_reg, mem_req_next;
  logic [31:0] inst_reg, inst_next;
  logic [31:0] inst_pc_reg, inst_pc_next;
  logic        inst_valid_reg, inst_valid_next;
  logic        misalign_reg, misalign_next;
  logic [23:0] byte_buf_reg, byte_buf_next;
  logic [2:0]  lane_sel;

  logic fetch_req, aligned, abort;

  // mem_busy is only looked at here; once a fetch is running the port is ours.
  assign fetch_req = ce && !br && !mem_busy;
  assign aligned   = (pc[1:0] == 2'b00);
  assign abort     = (state_reg != IDLE) && br;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else if (rdy) begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (fetch_req && aligned) state_next = B0;
      B0:      state_next = B1;
      B1:      state_next = B2;
      B2:      state_next = B3;
      B3:      state_next = B4;
      B4:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Output / datapath next values
  always_comb begin
    fpc_next        = fpc_reg;
    mem_a_next      = mem_a_reg;
    mem_req_next    = mem_req_reg;
    inst_next       = inst_reg;
    inst_pc_next    = inst_pc_reg;
    inst_valid_next = 1'b0;
    misalign_next   = 1'b0;
    if (abort) begin
      mem_req_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (fetch_req) begin
            if (aligned) begin
              fpc_next     = pc;
              mem_a_next   = pc;
              mem_req_next = 1'b1;
            end else begin
              misalign_next = 1'b1;
              inst_pc_next  = pc;
            end
          end
        end
        B0: mem_a_next = fpc_reg + 32'd1;
        B1: mem_a_next = fpc_reg + 32'd2;
        B2: mem_a_next = fpc_reg + 32'd3;
        B3: mem_req_next = 1'b0;
        B4: begin
          inst_next       = {mem_din, byte_buf_reg};
          inst_pc_next    = fpc_reg;
          inst_valid_next = 1'b1;
        end
        default: mem_req_next = 1'b0;
      endcase
    end
  end

  // Byte lane gi captures the byte returned while the FSM sits in B(gi+1).
  assign lane_sel = {state_reg == B3, state_reg == B2, state_reg == B1} & {3{!br}};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      assign byte_buf_next[gi*8 +: 8] = lane_sel[gi] ? mem_din : byte_buf_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      fpc_reg        <= 32'd0;
      mem_a_reg      <= 32'd0;
      mem_req_reg    <= 1'b0;
      inst_reg       <= 32'd0;
      inst_pc_reg    <= 32'd0;
      inst_valid_reg <= 1'b0;
      misalign_reg   <= 1'b0;
      byte_buf_reg   <= 24'd0;
    end else if (rdy) begin
      fpc_reg        <= fpc_next;
      mem_a_reg      <= mem_a_next;
      mem_req_reg    <= mem_req_next;
      inst_reg       <= inst_next;
      inst_pc_reg    <= inst_pc_next;
      inst_valid_reg <= inst_valid_next;
      misalign_reg   <= misalign_next;
      byte_buf_reg   <= byte_buf_next;
    end
  end

  assign mem_a      = mem_a_reg;
  assign mem_req    = mem_req_reg;
  assign inst       = inst_reg;
  assign inst_pc    = inst_pc_reg;
  assign inst_valid = inst_valid_reg;
  assign misalign   = misalign_reg;
  assign stall_req  = (state_reg != IDLE) && !br;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: byte memory model plus hand-computed expected words.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst, rdy, ce, br, mem_busy;
  logic [31:0] pc;
  logic [7:0]  mem_din;
  logic [31:0] mem_a, inst, inst_pc;
  logic        mem_req, inst_valid, misalign, stall_req;

  int errors = 0;
  int checks = 0;
  int valid_seen = 0;
  int req_seen = 0;
  int snap;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk), .rst(rst), .rdy(rdy), .pc(pc), .ce(ce), .br(br),
    .mem_busy(mem_busy), .mem_din(mem_din), .mem_a(mem_a), .mem_req(mem_req),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .misalign(misalign), .stall_req(stall_req)
  );

  // 0x100..0x103 hold 0x13,0x05,0x10,0x00; every other byte is addr[7:0]^0xA5.
  function automatic logic [7:0] byte_at(input logic [31:0] a);
    case (a)
      32'h100: byte_at = 8'h13;
      32'h101: byte_at = 8'h05;
      32'h102: byte_at = 8'h10;
      32'h103: byte_at = 8'h00;
      default: byte_at = a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Memory shares the global enable so a frozen fetch sees a frozen read port.
  always @(posedge clk) if (rdy) mem_din <= byte_at(mem_a);

  always @(negedge clk) begin
    if (inst_valid) valid_seen++;
    if (mem_req) req_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk32({tag, "_mem_a"}, mem_a, 32'h0);
    chk1({tag, "_mem_req"}, mem_req, 1'b0);
    chk32({tag, "_inst"}, inst, 32'h0);
    chk32({tag, "_inst_pc"}, inst_pc, 32'h0);
    chk1({tag, "_inst_valid"}, inst_valid, 1'b0);
    chk1({tag, "_misalign"}, misalign, 1'b0);
    chk1({tag, "_stall"}, stall_req, 1'b0);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; ce = 1'b0; br = 1'b0; mem_busy = 1'b0; pc = 32'h0;
    tick(); tick();
    chk_idle_outputs("reset");
    rst = 1'b1;
    tick();

    // Basic fetch of 0x100
    pc = 32'h100; ce = 1'b1;
    tick(); ce = 1'b0;
    chk32("f100_a0", mem_a, 32'h100); chk1("f100_req", mem_req, 1'b1); chk1("f100_stall", stall_req, 1'b1);
    tick(); chk32("f100_a1", mem_a, 32'h101);
    tick(); chk32("f100_a2", mem_a, 32'h102);
    tick(); chk32("f100_a3", mem_a, 32'h103); chk1("f100_req3", mem_req, 1'b1);
    tick(); chk1("f100_req_off", mem_req, 1'b0); chk1("f100_early_valid", inst_valid, 1'b0);
    tick();
    chk1("f100_valid", inst_valid, 1'b1); chk32("f100_inst", inst, 32'h00100513);
    chk32("f100_pc", inst_pc, 32'h100); chk1("f100_stall_done", stall_req, 1'b0);

    // Back-to-back accept in the inst_valid cycle, with address wrap
    pc = 32'hFFFF_FFFC; ce = 1'b1;
    tick(); ce = 1'b0;
    chk1("wrap_valid_clr", inst_valid, 1'b0); chk32("wrap_a0", mem_a, 32'hFFFF_FFFC);
    tick(); chk32("wrap_a1", mem_a, 32'hFFFF_FFFD);
    tick(); chk32("wrap_a2", mem_a, 32'hFFFF_FFFE);
    tick(); chk32("wrap_a3", mem_a, 32'hFFFF_FFFF);
    tick(); tick();
    chk1("wrap_valid", inst_valid, 1'b1); chk32("wrap_inst", inst, 32'h5A5B5859);
    chk32("wrap_pc", inst_pc, 32'hFFFF_FFFC);

    // Branch flush while in B2
    pc = 32'h300; ce = 1'b1;
    tick(); ce = 1'b0;
    tick(); tick();
    br = 1'b1; #1;
    chk1("br_stall", stall_req, 1'b0);
    snap = valid_seen;
    tick(); br = 1'b0; #1;
    chk1("br_req_off", mem_req, 1'b0); chk1("br_idle", stall_req, 1'b0);
    repeat (6) tick();
    chk32("br_no_valid", 32'(valid_seen - snap), 32'h0);

    // Misaligned pc
    snap = req_seen;
    pc = 32'h102; ce = 1'b1;
    tick(); ce = 1'b0;
    chk1("mis_pulse", misalign, 1'b1); chk32("mis_pc", inst_pc, 32'h102);
    chk1("mis_req", mem_req, 1'b0); chk1("mis_stall", stall_req, 1'b0);
    tick(); chk1("mis_clear", misalign, 1'b0);
    tick(); tick();
    chk32("mis_no_req", 32'(req_seen - snap), 32'h0);

    // mem_busy holds off acceptance, then is ignored mid-fetch
    pc = 32'h100; ce = 1'b1; mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk1("busy_no_accept", mem_req, 1'b0);
    end
    mem_busy = 1'b0;
    tick(); ce = 1'b0; mem_busy = 1'b1;
    chk1("busy_accept", mem_req, 1'b1); chk32("busy_a0", mem_a, 32'h100);
    repeat (5) tick();
    mem_busy = 1'b0;
    chk1("busy_valid", inst_valid, 1'b1); chk32("busy_inst", inst, 32'h00100513);

    // Reset during B3, then a clean fetch of 0x0
    pc = 32'h0; ce = 1'b1;
    tick(); ce = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk_idle_outputs("midrst");
    rst = 1'b1;
    snap = valid_seen;
    repeat (5) tick();
    chk32("midrst_no_valid", 32'(valid_seen - snap), 32'h0);
    ce = 1'b1;
    tick(); ce = 1'b0;
    repeat (5) tick();
    chk1("rst_fetch_valid", inst_valid, 1'b1); chk32("rst_fetch_inst", inst, 32'hA6A7A4A5);
    chk32("rst_fetch_pc", inst_pc, 32'h0);

    // rdy=0 for two cycles while in B1, then frozen valid pulse
    pc = 32'h200; ce = 1'b1;
    tick(); ce = 1'b0;
    tick(); chk32("rdy_a1", mem_a, 32'h201);
    rdy = 1'b0;
    tick(); chk32("rdy_hold1", mem_a, 32'h201);
    tick(); chk32("rdy_hold2", mem_a, 32'h201); chk1("rdy_stall", stall_req, 1'b1);
    rdy = 1'b1;
    tick(); chk32("rdy_a2", mem_a, 32'h202);
    tick(); chk32("rdy_a3", mem_a, 32'h203);
    tick(); chk1("rdy_req_off", mem_req, 1'b0);
    tick();
    chk1("rdy_valid", inst_valid, 1'b1); chk32("rdy_inst", inst, 32'hA6A7A4A5);
    chk32("rdy_pc", inst_pc, 32'h200);
    rdy = 1'b0;
    tick(); chk1("rdy_pulse_frozen", inst_valid, 1'b1);
    rdy = 1'b1;
    tick(); chk1("rdy_pulse_clear", inst_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
